// File: rtl/pes_vm_param.sv
// Single-product vending controller: accumulates 1/2-unit coins toward PRICE,
// vends one item, streams change back, and tracks a refillable stock count.
module pes_vm_param #(
  parameter int PRICE    = 3,
  parameter int CREDIT_W = 3,
  parameter int DEPTH    = 8,
  parameter int STOCK_W  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          in,
  input  logic                refill,
  output logic                out,
  output logic [1:0]          change,
  output logic [CREDIT_W-1:0] credit,
  output logic [STOCK_W-1:0]  stock,
  output logic                sold_out,
  output logic                busy
);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] TWO_C   = CREDIT_W'(2);
  localparam logic [STOCK_W-1:0]  DEPTH_C = STOCK_W'(DEPTH);

  state_t              r_state;
  state_t              w_nextState;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_nextCredit;
  logic [CREDIT_W-1:0] w_coinValue;
  logic [CREDIT_W-1:0] w_sum;
  logic [CREDIT_W-1:0] w_payValue;
  logic [STOCK_W-1:0]  r_stock;
  logic                w_isCoin;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= ACCEPT;
      r_credit <= '0;
    end else begin
      r_state  <= w_nextState;
      r_credit <= w_nextCredit;
    end
  end

  // Refill overrides the decrement taken on the VEND exit edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stock <= DEPTH_C;
    end else if (refill) begin
      r_stock <= DEPTH_C;
    end else if (r_state == VEND) begin
      r_stock <= r_stock - STOCK_W'(1);
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextCredit = r_credit;
    w_isCoin     = (in == 2'b01) || (in == 2'b10);
    w_coinValue  = (in == 2'b10) ? TWO_C : ((in == 2'b01) ? ONE_C : '0);
    w_sum        = r_credit + w_coinValue;
    w_payValue   = (r_credit >= TWO_C) ? TWO_C : ONE_C;
    case (r_state)
      ACCEPT: begin
        if (w_isCoin && !sold_out) begin
          w_nextCredit = w_sum;
          if (w_sum >= PRICE_C) begin
            w_nextState = VEND;
          end
        end else if (in == 2'b11 && r_credit != '0) begin
          w_nextState = CHANGE;
        end
      end
      VEND: begin
        w_nextCredit = r_credit - PRICE_C;
        w_nextState  = (r_credit != PRICE_C) ? CHANGE : ACCEPT;
      end
      CHANGE: begin
        w_nextCredit = r_credit - w_payValue;
        if (r_credit == w_payValue) begin
          w_nextState = ACCEPT;
        end
      end
      default: begin
        w_nextState  = ACCEPT;
        w_nextCredit = '0;
      end
    endcase
  end

  // Two-unit coins go out first so the refund stream is as short as possible.
  always_comb begin
    out      = (r_state == VEND);
    change   = 2'b00;
    if (r_state == CHANGE) begin
      change = (r_credit >= TWO_C) ? 2'b10 : 2'b01;
    end
    busy     = (r_state != ACCEPT);
    sold_out = (r_stock == '0);
    credit   = r_credit;
    stock    = r_stock;
  end

endmodule

// File: tb/tb_pes_vm_param.sv
// Directed bench for pes_vm_param: inputs driven 1 time unit after each rising
// edge, outputs checked there, against hand-computed values.
module tb_pes_vm_param;

  logic       clock;
  logic       reset;
  logic [1:0] in;
  logic       refill;
  logic       out;
  logic [1:0] change;
  logic [2:0] credit;
  logic [3:0] stock;
  logic       sold_out;
  logic       busy;

  int vectors;
  int miscompares;

  pes_vm_param #(
    .PRICE(3),
    .CREDIT_W(3),
    .DEPTH(8),
    .STOCK_W(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in(in),
    .refill(refill),
    .out(out),
    .change(change),
    .credit(credit),
    .stock(stock),
    .sold_out(sold_out),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic [1:0] coin, input logic rf);
    in     = coin;
    refill = rf;
    @(posedge clock);
    #1;
    in     = 2'b00;
    refill = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    in          = 2'b00;
    refill      = 1'b0;
    reset       = 1'b0;
    applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b00, 1'b1);
    reset = 1'b1;

    checkOutput("rst_credit", 32'(credit), 32'd0);
    checkOutput("rst_stock", 32'(stock), 32'd8);
    checkOutput("rst_out", 32'(out), 32'd0);
    checkOutput("rst_change", 32'(change), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_soldout", 32'(sold_out), 32'd0);

    // Exact price with single-unit coins
    applyStimulus(2'b01, 1'b0);
    checkOutput("c1_credit1", 32'(credit), 32'd1);
    applyStimulus(2'b01, 1'b0);
    checkOutput("c1_credit2", 32'(credit), 32'd2);
    checkOutput("c1_busy_acc", 32'(busy), 32'd0);
    applyStimulus(2'b01, 1'b0);
    checkOutput("c1_credit3", 32'(credit), 32'd3);
    checkOutput("c1_vend_out", 32'(out), 32'd1);
    checkOutput("c1_vend_chg", 32'(change), 32'd0);
    checkOutput("c1_vend_busy", 32'(busy), 32'd1);
    applyStimulus(2'b00, 1'b0);
    checkOutput("c1_post_out", 32'(out), 32'd0);
    checkOutput("c1_post_credit", 32'(credit), 32'd0);
    checkOutput("c1_post_stock", 32'(stock), 32'd7);
    checkOutput("c1_post_busy", 32'(busy), 32'd0);

    // Overpay by one, with coins offered during VEND and CHANGE
    applyStimulus(2'b10, 1'b0);
    checkOutput("c2_credit2", 32'(credit), 32'd2);
    applyStimulus(2'b10, 1'b0);
    checkOutput("c2_credit4", 32'(credit), 32'd4);
    checkOutput("c2_vend_out", 32'(out), 32'd1);
    applyStimulus(2'b01, 1'b0);
    checkOutput("c2_chg_coin", 32'(change), 32'd1);
    checkOutput("c2_chg_credit", 32'(credit), 32'd1);
    checkOutput("c2_chg_out", 32'(out), 32'd0);
    checkOutput("c2_chg_stock", 32'(stock), 32'd6);
    applyStimulus(2'b01, 1'b0);
    checkOutput("c2_end_credit", 32'(credit), 32'd0);
    checkOutput("c2_end_change", 32'(change), 32'd0);
    checkOutput("c2_end_busy", 32'(busy), 32'd0);

    // Cancel with credit 2 refunds a single two-unit coin
    applyStimulus(2'b10, 1'b0);
    applyStimulus(2'b11, 1'b0);
    checkOutput("c3_ref_change", 32'(change), 32'd2);
    checkOutput("c3_ref_out", 32'(out), 32'd0);
    checkOutput("c3_ref_busy", 32'(busy), 32'd1);
    applyStimulus(2'b00, 1'b0);
    checkOutput("c3_end_credit", 32'(credit), 32'd0);
    checkOutput("c3_end_busy", 32'(busy), 32'd0);
    checkOutput("c3_end_stock", 32'(stock), 32'd6);
    applyStimulus(2'b11, 1'b0);
    checkOutput("c3_zero_busy", 32'(busy), 32'd0);
    checkOutput("c3_zero_change", 32'(change), 32'd0);

    // Refill on the VEND exit edge beats the decrement
    applyStimulus(2'b01, 1'b0);
    applyStimulus(2'b10, 1'b0);
    checkOutput("c4_vend_out", 32'(out), 32'd1);
    applyStimulus(2'b00, 1'b1);
    checkOutput("c4_refill_stock", 32'(stock), 32'd8);
    checkOutput("c4_refill_credit", 32'(credit), 32'd0);

    // Drain all eight items, then coins are rejected until refill
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'b10, 1'b0);
      applyStimulus(2'b01, 1'b0);
      applyStimulus(2'b00, 1'b0);
    end
    checkOutput("c5_empty_stock", 32'(stock), 32'd0);
    checkOutput("c5_empty_soldout", 32'(sold_out), 32'd1);
    applyStimulus(2'b10, 1'b0);
    checkOutput("c5_reject_credit", 32'(credit), 32'd0);
    checkOutput("c5_reject_busy", 32'(busy), 32'd0);
    applyStimulus(2'b00, 1'b1);
    checkOutput("c5_refill_stock", 32'(stock), 32'd8);
    checkOutput("c5_refill_soldout", 32'(sold_out), 32'd0);

    // Reset during CHANGE drops the pending coin
    applyStimulus(2'b10, 1'b0);
    applyStimulus(2'b10, 1'b0);
    applyStimulus(2'b00, 1'b0);
    checkOutput("c6_chg_credit", 32'(credit), 32'd1);
    checkOutput("c6_chg_stock", 32'(stock), 32'd7);
    reset = 1'b0;
    applyStimulus(2'b00, 1'b0);
    reset = 1'b1;
    checkOutput("c6_rst_credit", 32'(credit), 32'd0);
    checkOutput("c6_rst_change", 32'(change), 32'd0);
    checkOutput("c6_rst_out", 32'(out), 32'd0);
    checkOutput("c6_rst_busy", 32'(busy), 32'd0);
    checkOutput("c6_rst_stock", 32'(stock), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
